// File: rtl/sym_delay_aligner.sv
// rtl/sym_delay_aligner.sv - symbol delay sweep, min-error lock and per-window error counting
// Optional: SYM_ALIGN_EARLY_EXIT_EN locks at the first zero-error window.
module sym_delay_aligner #(
    parameter int WINDOW_LOG2 = 10,
    parameter int SETTLE_SYMS = 4,
    parameter int MAX_DELAY   = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sym_clk_en,
    input  logic                     start,
    input  logic signed [17:0]       ref_in,
    input  logic signed [17:0]       dec_in,
    output logic [7:0]               delay,
    output logic                     locked,
    output logic [WINDOW_LOG2:0]     err_count,
    output logic                     err_valid,
    output logic [WINDOW_LOG2:0]     best_errors
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_NEXT,
        S_TRACK
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [7:0]             settle_cnt;
    logic [7:0]             best_delay;
    logic [WINDOW_LOG2-1:0] sym_cnt;
    logic [WINDOW_LOG2:0]   acc;
    logic [WINDOW_LOG2:0]   acc_inc;
    logic                   mismatch;
    logic                   settle_done;
    logic                   window_done;
    logic                   new_best;
    logic                   last_delay;
    logic                   zero_exit;

    assign mismatch    = (ref_in != dec_in);
    assign acc_inc     = acc + {{WINDOW_LOG2{1'b0}}, mismatch};
    assign settle_done = sym_clk_en && (settle_cnt == 8'(SETTLE_SYMS - 1));
    assign window_done = sym_clk_en && (&sym_cnt);
    assign new_best    = (err_count < best_errors);
    assign last_delay  = (delay == 8'(MAX_DELAY));
    assign locked      = (state == S_TRACK);

`ifdef SYM_ALIGN_EARLY_EXIT_EN
    assign zero_exit = (err_count == '0);
`else
    assign zero_exit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start restarts the sweep from any state, including mid-window
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_SETTLE;
        end else begin
            case (state)
                S_IDLE:    state_nxt = S_IDLE;
                S_SETTLE:  if (settle_done) state_nxt = S_MEASURE;
                S_MEASURE: if (window_done) state_nxt = S_NEXT;
                S_NEXT:    state_nxt = (zero_exit || last_delay) ? S_TRACK : S_SETTLE;
                S_TRACK:   state_nxt = S_TRACK;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            delay       <= '0;
            err_count   <= '0;
            err_valid   <= 1'b0;
            best_errors <= '1;
            best_delay  <= '0;
            settle_cnt  <= '0;
            sym_cnt     <= '0;
            acc         <= '0;
        end else begin
            err_valid <= 1'b0;
            if (start) begin
                delay       <= '0;
                best_errors <= '1;
                best_delay  <= '0;
                settle_cnt  <= '0;
                sym_cnt     <= '0;
                acc         <= '0;
            end else begin
                case (state)
                    S_SETTLE: begin
                        if (sym_clk_en) begin
                            settle_cnt <= settle_done ? 8'd0 : settle_cnt + 8'd1;
                        end
                        if (settle_done) begin
                            sym_cnt <= '0;
                            acc     <= '0;
                        end
                    end
                    S_MEASURE, S_TRACK: begin
                        if (sym_clk_en) begin
                            sym_cnt <= sym_cnt + WINDOW_LOG2'(1);
                            acc     <= window_done ? '0 : acc_inc;
                        end
                        if (window_done) begin
                            err_count <= acc_inc;
                            err_valid <= 1'b1;
                        end
                    end
                    S_NEXT: begin
                        settle_cnt <= '0;
                        // strict compare: ties keep the lower delay already recorded
                        if (new_best) begin
                            best_errors <= err_count;
                            best_delay  <= delay;
                        end
                        if (!zero_exit) begin
                            if (last_delay) begin
                                delay <= new_best ? delay : best_delay;
                            end else begin
                                delay <= delay + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sym_delay_aligner.sv
// tb/tb_sym_delay_aligner.sv - scoreboard bench for sym_delay_aligner
module tb_sym_delay_aligner;

    localparam int WL = 4;
    localparam int SS = 2;
    localparam int MD = 15;
    localparam int WIN = 1 << WL;
    localparam int ALL_ONES = (1 << (WL + 1)) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               sym_clk_en;
    logic               start;
    logic signed [17:0] ref_in;
    logic signed [17:0] dec_in;
    logic [7:0]         delay;
    logic               locked;
    logic [WL:0]        err_count;
    logic               err_valid;
    logic [WL:0]        best_errors;

    sym_delay_aligner #(
        .WINDOW_LOG2(WL),
        .SETTLE_SYMS(SS),
        .MAX_DELAY  (MD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sym_clk_en (sym_clk_en),
        .start      (start),
        .ref_in     (ref_in),
        .dec_in     (dec_in),
        .delay      (delay),
        .locked     (locked),
        .err_count  (err_count),
        .err_valid  (err_valid),
        .best_errors(best_errors)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int dly;
        int lk;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   sidx = 0;
    int   align = 0;
    int   err_mode = 0;
    bit   prev_ev = 1'b0;

    function automatic logic signed [17:0] mk(int i);
        return 18'((i + 4096) & 255);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clk: present the delay-line output for the current delay select and the slicer decision
    task automatic tick(bit en, bit st);
        logic signed [17:0] d;
        int ph;
        sym_clk_en = en;
        start      = st;
        ref_in     = mk(sidx - int'(delay));
        d          = mk(sidx - align);
        ph         = sidx % WIN;
        if (err_mode == 2 || (err_mode == 1 && (ph == 1 || ph == 7 || ph == 12)))
            d[17] = ~d[17];
        dec_in = d;
        @(posedge clk);
        #1;
        if (en) sidx++;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && err_valid) begin
            chk("err_valid_width", int'(prev_ev), 0);
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_err_valid: got pulse with err_count %0d at delay %0d, expected none",
                         err_count, delay);
            end else begin
                e = q.pop_front();
                chk("err_count", int'(err_count), e.cnt);
                chk("window_delay", int'(delay), e.dly);
                chk("window_locked", int'(locked), e.lk);
            end
        end
        prev_ev = err_valid;
    end

    // mode 0: ideal link, 1: three errors per window, 2: every symbol wrong
    task automatic run_sweep(int a, int mode, int n_track, int pause_at);
        int last;
        int dbest;
        int best;
        int t;
        int hold_d;
        int hold_c;
        align    = a;
        err_mode = mode;
        last     = MD;
`ifdef SYM_ALIGN_EARLY_EXIT_EN
        if (mode == 0) last = a;
`endif
        for (int d = 0; d <= last; d++) begin
            if (mode == 2 || d != a) q.push_back('{WIN, d, 0});
            else                     q.push_back('{(mode == 1) ? 3 : 0, d, 0});
        end
        dbest = (mode == 2) ? 0 : a;
        best  = (mode == 0) ? 0 : ((mode == 1) ? 3 : WIN);
        for (int i = 0; i < n_track; i++) q.push_back('{best, dbest, 1});

        tick(1'b1, 1'b1);
        chk("restart_locked", int'(locked), 0);
        chk("restart_delay", int'(delay), 0);
        chk("restart_best", int'(best_errors), ALL_ONES);

        t = 0;
        while (q.size() > 0 && t < 3000) begin
            if (t == pause_at) begin
                hold_d = int'(delay);
                hold_c = int'(err_count);
                repeat (1000) tick(1'b0, 1'b0);
                chk("pause_delay", int'(delay), hold_d);
                chk("pause_err_count", int'(err_count), hold_c);
                chk("pause_locked", int'(locked), 0);
            end
            tick(1'b1, 1'b0);
            t++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sweep_timeout: got %0d windows outstanding, expected 0", q.size());
            q.delete();
        end
        chk("lock_locked", int'(locked), 1);
        chk("lock_delay", int'(delay), dbest);
        chk("lock_best", int'(best_errors), best);
        repeat (5) tick(1'b1, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        sym_clk_en = 1'b0;
        start      = 1'b0;
        ref_in     = '0;
        dec_in     = '0;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        reset = 1'b1;
        chk("rst_delay", int'(delay), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_err_valid", int'(err_valid), 0);
        chk("rst_best", int'(best_errors), ALL_ONES);

        run_sweep(5, 0, 3, -1);
        run_sweep(9, 1, 3, -1);
        run_sweep(0, 2, 2, -1);
        run_sweep(5, 0, 2, 45);

        // reset in the middle of delay 2's measurement window
        align    = 5;
        err_mode = 0;
        for (int d = 0; d <= MD; d++) q.push_back('{(d == 5) ? 0 : WIN, d, 0});
        tick(1'b1, 1'b1);
        repeat (49) tick(1'b1, 1'b0);
        chk("pre_reset_delay", int'(delay), 2);
        q.delete();
        reset = 1'b0;
        tick(1'b1, 1'b1);
        reset = 1'b1;
        chk("mid_rst_delay", int'(delay), 0);
        chk("mid_rst_locked", int'(locked), 0);
        chk("mid_rst_err_valid", int'(err_valid), 0);
        chk("mid_rst_err_count", int'(err_count), 0);
        chk("mid_rst_best", int'(best_errors), ALL_ONES);
        repeat (100) tick(1'b1, 1'b0);
        chk("idle_delay", int'(delay), 0);
        chk("idle_locked", int'(locked), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
